// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA grid timing generator.
// Default mode is 640x350 @ 25 MHz pixel rate from a 50 MHz FCLK.
package vga_timing_pkg;

  localparam int POS_W = 11;

  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_H_VIS   = 640;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_V_VIS   = 350;
  localparam int DEF_V_FP    = 37;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BP    = 60;
  localparam int DEF_GRID_SH = 6;

  // RGB332 field positions inside an 8-bit pixel.
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int vis, input int fp);
    return vis + fp;
  endfunction

  function automatic int sync_end(input int vis, input int fp, input int sync);
    return vis + fp + sync;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_grid_timing_gen_if.sv
// Pixel-side and DAC-side signals of the VGA grid timing generator.
// There is no valid/ready: the generator publishes POS_X/POS_Y every FCLK and the
// pixel source must return PIXEL_DATA for that position combinationally in the same cycle.
interface vga_grid_timing_gen_if;
  import vga_timing_pkg::*;

  logic [7:0]       PIXEL_DATA;
  logic             PIX_CE;
  logic             DISPLAY_EN;
  logic [POS_W-1:0] POS_X;
  logic [POS_W-1:0] POS_Y;
  logic [2:0]       R;
  logic [2:0]       G;
  logic [1:0]       B;
  logic             HSYNC;
  logic             VSYNC;

  modport master (
    input  PIXEL_DATA,
    output PIX_CE, DISPLAY_EN, POS_X, POS_Y, R, G, B, HSYNC, VSYNC
  );

  modport slave (
    output PIXEL_DATA,
    input  PIX_CE, DISPLAY_EN, POS_X, POS_Y, R, G, B, HSYNC, VSYNC
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One display axis: wrap counter advanced by en, with visible and active-low sync decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS  = DEF_H_VIS,
  parameter int FP   = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP   = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output logic             visible,
  output logic             sync_n
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(axis_total(VIS, FP, SYNC, BP) - 1);
  localparam logic [POS_W-1:0] VIS_END  = POS_W'(VIS);
  localparam logic [POS_W-1:0] SYNC_LO  = POS_W'(sync_start(VIS, FP));
  localparam logic [POS_W-1:0] SYNC_HI  = POS_W'(sync_end(VIS, FP, SYNC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (en) begin
      pos <= (pos == LAST_POS) ? '0 : pos + 1'b1;
    end
  end

  assign visible = (pos < VIS_END);
  assign sync_n  = !((pos >= SYNC_LO) && (pos < SYNC_HI));

endmodule

// File: rtl/vga_grid_timing_gen.sv
// VGA timing generator with a grid colour overlay on RGB332 pixels.
// Define VGA_GRID_CHECKER_EN for a checkerboard overlay; default is column stripes.
module vga_grid_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_VIS   = DEF_H_VIS,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_VIS   = DEF_V_VIS,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  parameter int GRID_SH = DEF_GRID_SH
) (
  input  logic                  FCLK,
  input  logic                  RST_IN,
  vga_grid_timing_gen_if.master vga
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [POS_W-1:0] H_LAST   = POS_W'(axis_total(H_VIS, H_FP, H_SYNC, H_BP) - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_ce;
  logic [POS_W-1:0] h_pos, v_pos;
  logic             h_vis, v_vis, h_sync_n, v_sync_n;
  logic             h_wrap, de, inv;
  logic [7:0]       pix, rgb;

  always_ff @(posedge FCLK or negedge RST_IN) begin
    if (!RST_IN) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // Gated by reset so a CLK_DIV=1 build does not strobe while held in reset.
  assign pix_ce = RST_IN && (div_cnt == DIV_LAST);
  assign h_wrap = pix_ce && (h_pos == H_LAST);

  vga_axis_counter #(.VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
    .clk(FCLK), .rst_n(RST_IN), .en(pix_ce),
    .pos(h_pos), .visible(h_vis), .sync_n(h_sync_n)
  );

  vga_axis_counter #(.VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
    .clk(FCLK), .rst_n(RST_IN), .en(h_wrap),
    .pos(v_pos), .visible(v_vis), .sync_n(v_sync_n)
  );

  // Bit GRID_SH of a position is bit 0 of its grid cell index.
`ifdef VGA_GRID_CHECKER_EN
  assign inv = h_pos[GRID_SH] ^ v_pos[GRID_SH];
`else
  assign inv = h_pos[GRID_SH];
`endif

  assign de  = RST_IN && h_vis && v_vis;
  assign pix = vga.PIXEL_DATA ^ {8{inv}};
  assign rgb = de ? pix : 8'h00;

  assign vga.PIX_CE     = pix_ce;
  assign vga.DISPLAY_EN = de;
  assign vga.POS_X      = h_pos;
  assign vga.POS_Y      = v_pos;
  assign vga.R          = rgb[R_MSB:R_LSB];
  assign vga.G          = rgb[G_MSB:G_LSB];
  assign vga.B          = rgb[B_MSB:B_LSB];
  assign vga.HSYNC      = !RST_IN || h_sync_n;
  assign vga.VSYNC      = !RST_IN || v_sync_n;

endmodule

// File: tb/tb_vga_grid_timing_gen.sv
// Bench for vga_grid_timing_gen: a default-mode instance and a tiny CLK_DIV=1 mode,
// both compared every FCLK against a position-from-cycle-count reference model.
module tb_vga_grid_timing_gen;
  import vga_timing_pkg::*;

  localparam int S_DIV = 1;
  localparam int S_HV = 20, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VV = 10, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_GS = 2;
  localparam int S_FRAME = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB) * S_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix = 8'h00;
  int         cyc;
  int         n_checks = 0;
  int         n_errors = 0;

  bit collect = 0;
  int hs_cnt = 0, hs_first = -1, hs_last = -1, de_off_first = -1, vs_lines = 0;

  vga_grid_timing_gen_if d_if ();
  vga_grid_timing_gen_if s_if ();
  assign d_if.PIXEL_DATA = pix;
  assign s_if.PIXEL_DATA = pix;

  vga_grid_timing_gen u_def (.FCLK(clk), .RST_IN(rst_n), .vga(d_if.master));

  vga_grid_timing_gen #(
    .CLK_DIV(S_DIV), .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .GRID_SH(S_GS)
  ) u_small (.FCLK(clk), .RST_IN(rst_n), .vga(s_if.master));

  always #5 clk = ~clk;

  // Model time base: FCLK edges seen since reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [63:0] obs_d, obs_s;
  assign obs_d = {30'd0, d_if.PIX_CE, d_if.DISPLAY_EN, d_if.HSYNC, d_if.VSYNC,
                  d_if.POS_X, d_if.POS_Y, d_if.R, d_if.G, d_if.B};
  assign obs_s = {30'd0, s_if.PIX_CE, s_if.DISPLAY_EN, s_if.HSYNC, s_if.VSYNC,
                  s_if.POS_X, s_if.POS_Y, s_if.R, s_if.G, s_if.B};

  function automatic logic [63:0] model(input int k, input logic rst, input logic [7:0] pd,
                                        input int div, input int hv, input int hf, input int hs,
                                        input int hb, input int vv, input int vf, input int vs,
                                        input int vb, input int gs);
    int ht, vt, p, x, y;
    logic ce, de, hsn, vsn, inv;
    logic [7:0] rgb;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    p   = k / div;
    x   = p % ht;
    y   = (p / ht) % vt;
    ce  = rst && ((k % div) == div - 1);
    de  = rst && (x < hv) && (y < vv);
    hsn = !rst || !((x >= hv + hf) && (x < hv + hf + hs));
    vsn = !rst || !((y >= vv + vf) && (y < vv + vf + vs));
    inv = ((x >> gs) & 1) != 0;
`ifdef VGA_GRID_CHECKER_EN
    inv = inv ^ (((y >> gs) & 1) != 0);
`endif
    rgb = de ? (inv ? ~pd : pd) : 8'h00;
    return {30'd0, ce, de, hsn, vsn, 11'(x), 11'(y), rgb};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_eq("def_outs", obs_d, model(cyc, rst_n, pix, DEF_CLK_DIV, DEF_H_VIS, DEF_H_FP,
             DEF_H_SYNC, DEF_H_BP, DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP, DEF_GRID_SH));
    check_eq("small_outs", obs_s, model(cyc, rst_n, pix, S_DIV, S_HV, S_HF, S_HS, S_HB,
             S_VV, S_VF, S_VS, S_VB, S_GS));
    if (collect) begin
      if (d_if.PIX_CE && d_if.POS_Y == 11'd0) begin
        if (!d_if.HSYNC) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(d_if.POS_X);
          hs_last = int'(d_if.POS_X);
        end
        if (!d_if.DISPLAY_EN && de_off_first < 0) de_off_first = int'(d_if.POS_X);
      end
      if (cyc < S_FRAME && s_if.PIX_CE && s_if.POS_X == 11'd0 && !s_if.VSYNC) vs_lines++;
      if (cyc == S_FRAME - 1) check_eq("small_frame_last", {s_if.POS_X, s_if.POS_Y}, {11'd31, 11'd16});
      if (cyc == S_FRAME)     check_eq("small_frame_wrap", {s_if.POS_X, s_if.POS_Y}, 22'd0);
      if (cyc == 1599)        check_eq("def_line_last", {d_if.POS_X, d_if.POS_Y}, {11'd799, 11'd0});
      if (cyc == 1600)        check_eq("def_line_wrap", {d_if.POS_X, d_if.POS_Y}, {11'd0, 11'd1});
    end
    pix = 8'($urandom);
  endtask

  task automatic run_def_to(input int x_target);
    int guard = 0;
    while (cyc < 2 * x_target && guard < 2000) begin
      step();
      guard++;
    end
    check_eq("run_to_bound", {32'(cyc)}, {32'(2 * x_target)});
  endtask

  initial begin
    rst_n = 1'b0;
    pix   = 8'($urandom);
    repeat (4) step();
    check_eq("rst_pos", {d_if.POS_X, d_if.POS_Y}, 22'd0);
    check_eq("rst_blank", {d_if.DISPLAY_EN, d_if.HSYNC, d_if.VSYNC, d_if.R, d_if.G, d_if.B},
             {1'b0, 1'b1, 1'b1, 8'h00});

    rst_n   = 1'b1;
    collect = 1;
    check_eq("rel_pos", {d_if.POS_X, d_if.POS_Y}, 22'd0);
    for (int j = 1; j <= 6; j++) begin
      step();
      check_eq("ce_phase", {31'd0, d_if.PIX_CE}, {31'd0, (j % 2) == 1});
      check_eq("x_advance", {d_if.POS_X}, 11'(j / 2));
    end

    run_def_to(10);
    pix = 8'hE5;
    #1;
    check_eq("col_x10_rgb", {d_if.R, d_if.G, d_if.B}, {3'd7, 3'd1, 2'd1});
    run_def_to(70);
    pix = 8'hE5;
    #1;
    check_eq("col_x70_inv", {d_if.R, d_if.G, d_if.B}, 8'h1A);
    run_def_to(700);
    pix = 8'hE5;
    #1;
    check_eq("col_x700_blank", {d_if.R, d_if.G, d_if.B}, 8'h00);

    while (cyc < 1610) step();
    collect = 0;
    check_eq("hsync_width", 32'(hs_cnt), 32'd96);
    check_eq("hsync_first", 32'(hs_first), 32'd656);
    check_eq("hsync_last", 32'(hs_last), 32'd751);
    check_eq("de_off_x", 32'(de_off_first), 32'd640);
    check_eq("small_vsync_lines", 32'(vs_lines), 32'(S_VS));

    // Mid-frame resets at random points, asserted between clock edges.
    repeat (3) begin
      repeat ($urandom_range(100, 900)) step();
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_def", {d_if.DISPLAY_EN, d_if.HSYNC, d_if.VSYNC, d_if.R, d_if.G, d_if.B},
               {1'b0, 1'b1, 1'b1, 8'h00});
      check_eq("midrst_small", {s_if.DISPLAY_EN, s_if.HSYNC, s_if.VSYNC, s_if.R, s_if.G, s_if.B},
               {1'b0, 1'b1, 1'b1, 8'h00});
      repeat ($urandom_range(1, 4)) step();
      rst_n = 1'b1;
      check_eq("midrst_restart", {d_if.POS_X, d_if.POS_Y, s_if.POS_X, s_if.POS_Y}, 44'd0);
    end

    repeat (1200) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
